serial_frame_tx_1010: RTL and testbench



---
 rtl/serial_frame_tx_1010_if.sv | 22 ++
 rtl/serial_frame_tx_1010.sv | 134 +++++++++++++
 tb/tb_serial_frame_tx_1010.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_1010_if.sv
// Handshake and serial-line bundle for serial_frame_tx_1010.
// The word source is the master; the transmitter is the slave.
interface serial_frame_tx_1010_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              sout;
    logic              frame_active;
    logic              tx_done;

    modport master (
        output in_valid, in_data,
        input  in_ready, sout, frame_active, tx_done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, sout, frame_active, tx_done
    );
endinterface

// File: rtl/serial_frame_tx_1010.sv
// Serial frame transmitter: preamble, MSB-first payload, idle-low gap.
// Feeds the Mealy 1010 detector at the far end of the link.
module serial_frame_tx_1010 #(
    parameter int               DATA_W     = 8,
    parameter int               PRE_W      = 4,
    parameter logic [PRE_W-1:0] PREAMBLE   = 4'b1010,
    parameter int               GAP_CYCLES = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_frame_tx_1010_if.slave tx_if
);
    localparam int TOT_W = PRE_W + DATA_W;
    localparam int MAX_A = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int MAX_C = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CW    = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] PRE_LD = CW'(PRE_W - 1);
    localparam logic [CW-1:0] DAT_LD = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LD =
        CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TOT_W-1:0]  sh_q, sh_d;
    logic              sout_q, sout_d;
    logic              act_q, act_d;
    logic              done_q, done_d;
    logic              rdy_q, rdy_d;
    logic              accept;

    assign accept = tx_if.in_valid & rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            sout_q  <= 1'b0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            sout_q  <= sout_d;
            act_q   <= act_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    // cnt_q holds the cycles remaining in the current phase after this one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_PRE;
                    cnt_d   = PRE_LD;
                    sh_d    = {PREAMBLE, tx_if.in_data};
                end
            end
            S_PRE: begin
                sh_d = sh_q << 1;
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    cnt_d   = DAT_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                sh_d = sh_q << 1;
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so decode them from the next state
    always_comb begin
        sout_d = 1'b0;
        act_d  = 1'b0;
        done_d = 1'b0;
        rdy_d  = 1'b0;
        unique case (state_d)
            S_IDLE: rdy_d = 1'b1;
            S_PRE: begin
                act_d  = 1'b1;
                sout_d = sh_d[TOT_W-1];
            end
            S_DATA: begin
                act_d  = 1'b1;
                sout_d = sh_d[TOT_W-1];
                done_d = (cnt_d == '0);
            end
            S_GAP:   sout_d = 1'b0;
            default: sout_d = 1'b0;
        endcase
    end

    assign tx_if.in_ready     = rdy_q;
    assign tx_if.sout         = sout_q;
    assign tx_if.frame_active = act_q;
    assign tx_if.tx_done      = done_q;
endmodule

// File: tb/tb_serial_frame_tx_1010.sv
// Directed bench for serial_frame_tx_1010 with a per-cycle scoreboard
// and a non-overlapping Mealy 1010 detector on the serial line.
module tb_serial_frame_tx_1010;
    typedef struct packed {
        logic s;
        logic fa;
        logic dn;
        logic rdy;
        logic z;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    rec_t q[$];
    logic [1:0] dst = 2'd0;

    always #5 clk = ~clk;

    serial_frame_tx_1010_if #(.DATA_W(8)) ifa ();
    serial_frame_tx_1010_if #(.DATA_W(1)) ifb ();

    serial_frame_tx_1010 dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .tx_if (ifa)
    );

    serial_frame_tx_1010 #(
        .DATA_W     (1),
        .GAP_CYCLES (0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .tx_if (ifb)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sout"}, ifa.sout, 1'b0);
        chk({tag, "_active"}, ifa.frame_active, 1'b0);
        chk({tag, "_done"}, ifa.tx_done, 1'b0);
        chk({tag, "_ready"}, ifa.in_ready, 1'b1);
    endtask

    task automatic push_frame(input logic [7:0] w, input int dw,
                              input int gap);
        logic [3:0] pre;
        rec_t r;
        pre = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            r = '{s: pre[i], fa: 1'b1, dn: 1'b0, rdy: 1'b0, z: 1'b0};
            q.push_back(r);
        end
        for (int i = dw - 1; i >= 0; i--) begin
            r = '{s: w[i], fa: 1'b1, dn: (i == 0), rdy: 1'b0, z: 1'b0};
            q.push_back(r);
        end
        for (int i = 0; i < gap; i++) begin
            r = '{s: 1'b0, fa: 1'b0, dn: 1'b0, rdy: 1'b0, z: 1'b0};
            q.push_back(r);
        end
        r = '{s: 1'b0, fa: 1'b0, dn: 1'b0, rdy: 1'b1, z: 1'b0};
        q.push_back(r);
    endtask

    task automatic run_q(input bit b, input bit use_z, input int n);
        rec_t r;
        logic s, zo;
        int k;
        k = 0;
        while (q.size() > 0 && k < n) begin
            @(negedge clk);
            r = q.pop_front();
            k++;
            s = b ? ifb.sout : ifa.sout;
            chk("sout", s, r.s);
            chk("frame_active", b ? ifb.frame_active : ifa.frame_active,
                r.fa);
            chk("tx_done", b ? ifb.tx_done : ifa.tx_done, r.dn);
            chk("in_ready", b ? ifb.in_ready : ifa.in_ready, r.rdy);
            if (!b) begin
                zo = 1'b0;
                case (dst)
                    2'd0: dst = s ? 2'd1 : 2'd0;
                    2'd1: dst = s ? 2'd1 : 2'd2;
                    2'd2: dst = s ? 2'd3 : 2'd0;
                    default: begin
                        zo  = !s;
                        dst = s ? 2'd1 : 2'd0;
                    end
                endcase
                if (use_z) chk("detector_z", zo, r.z);
            end
        end
    endtask

    task automatic send(input logic [7:0] w, input bit hold);
        int n;
        n = 0;
        while (ifa.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", ifa.in_ready, 1'b1);
        ifa.in_valid = 1'b1;
        ifa.in_data  = w;
        @(posedge clk);
        #1;
        if (!hold) ifa.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.in_valid = 1'b1;
        ifa.in_data  = 8'hC5;
        ifb.in_valid = 1'b0;
        ifb.in_data  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle("reset");
        end
        ifa.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        push_frame(8'hC5, 8, 2);
        send(8'hC5, 1'b0);
        run_q(1'b0, 1'b0, 1000);

        push_frame(8'hFF, 8, 2);
        send(8'hFF, 1'b1);
        ifa.in_data = 8'h01;
        run_q(1'b0, 1'b0, 1000);
        push_frame(8'h01, 8, 2);
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        run_q(1'b0, 1'b0, 1000);
        @(negedge clk);
        chk_idle("b2b_no_repeat");

        push_frame(8'h00, 8, 2);
        q[3].z = 1'b1;
        send(8'h00, 1'b0);
        run_q(1'b0, 1'b1, 1000);

        push_frame(8'hAA, 8, 2);
        q[3].z  = 1'b1;
        q[7].z  = 1'b1;
        q[11].z = 1'b1;
        send(8'hAA, 1'b0);
        run_q(1'b0, 1'b1, 1000);

        push_frame(8'hC5, 8, 2);
        send(8'hC5, 1'b0);
        run_q(1'b0, 1'b0, 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("mid_reset");
        q.delete();
        dst = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("mid_release");
        push_frame(8'h3C, 8, 2);
        send(8'h3C, 1'b0);
        run_q(1'b0, 1'b0, 1000);

        for (int f = 0; f < 3; f++) push_frame(8'h01, 1, 0);
        ifb.in_valid = 1'b1;
        @(posedge clk);
        #1;
        run_q(1'b1, 1'b0, 17);
        ifb.in_valid = 1'b0;
        run_q(1'b1, 1'b0, 1);
        @(negedge clk);
        chk("corner_stop_sout", ifb.sout, 1'b0);
        chk("corner_stop_ready", ifb.in_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
